// File: rtl/gam_assoc_layer_controller_pkg.sv
// GAM_package: shared types and default constants for the GAM associative layer
package GAM_package;

    localparam int ASSOC_CLASS_W  = 4;
    localparam int ASSOC_LINKS    = 4;
    localparam int ASSOC_WEIGHT_W = 8;

    typedef enum logic {
        LEARNING = 1'b0,
        RECALL   = 1'b1
    } LEARNING_RECALL_T;

    typedef enum logic [2:0] {
        IDLE,
        SCAN_L,
        SCAN_R,
        UPDATE,
        DONE
    } ASSOC_STATE_T;

    typedef struct packed {
        logic                      valid;
        logic [ASSOC_CLASS_W-1:0]  resp;
        logic [ASSOC_WEIGHT_W-1:0] weight;
    } assoc_link_t;

endpackage

// File: rtl/gam_assoc_layer_controller_slot_scan.sv
// gam_assoc_slot_scan: running first-free / min-weight / max-weight slot tracker, lowest index wins ties
module gam_assoc_slot_scan
    import GAM_package::*;
#(
    parameter int LINKS  = ASSOC_LINKS,
    parameter int SLOT_W = $clog2(LINKS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic [SLOT_W-1:0] idx,
    input  assoc_link_t       link,
    output logic              free_found,
    output logic [SLOT_W-1:0] free_idx,
    output logic [SLOT_W-1:0] min_idx,
    output logic              max_found,
    output logic [SLOT_W-1:0] max_idx
);

    logic                      free_found_q, free_found_d;
    logic [SLOT_W-1:0]         free_idx_q, free_idx_d;
    logic                      min_found_q, min_found_d;
    logic [SLOT_W-1:0]         min_idx_q, min_idx_d;
    logic [ASSOC_WEIGHT_W-1:0] min_w_q, min_w_d;
    logic                      max_found_q, max_found_d;
    logic [SLOT_W-1:0]         max_idx_q, max_idx_d;
    logic [ASSOC_WEIGHT_W-1:0] max_w_q, max_w_d;

    // Fold the presented slot into the running bests; strict compares keep the earlier slot on ties
    always_comb begin
        free_found_d = free_found_q & ~clear;
        free_idx_d   = free_idx_q;
        min_found_d  = min_found_q & ~clear;
        min_idx_d    = min_idx_q;
        min_w_d      = min_w_q;
        max_found_d  = max_found_q & ~clear;
        max_idx_d    = max_idx_q;
        max_w_d      = max_w_q;
        if (en && !link.valid && !free_found_d) begin
            free_found_d = 1'b1;
            free_idx_d   = idx;
        end
        if (en && link.valid && (!min_found_d || link.weight < min_w_d)) begin
            min_found_d = 1'b1;
            min_idx_d   = idx;
            min_w_d     = link.weight;
        end
        if (en && link.valid && (!max_found_d || link.weight > max_w_d)) begin
            max_found_d = 1'b1;
            max_idx_d   = idx;
            max_w_d     = link.weight;
        end
    end

    // Tracker state register
    always_ff @(posedge clk) begin
        if (reset) begin
            free_found_q <= 1'b0;
            free_idx_q   <= '0;
            min_found_q  <= 1'b0;
            min_idx_q    <= '0;
            min_w_q      <= '0;
            max_found_q  <= 1'b0;
            max_idx_q    <= '0;
            max_w_q      <= '0;
        end else begin
            free_found_q <= free_found_d;
            free_idx_q   <= free_idx_d;
            min_found_q  <= min_found_d;
            min_idx_q    <= min_idx_d;
            min_w_q      <= min_w_d;
            max_found_q  <= max_found_d;
            max_idx_q    <= max_idx_d;
            max_w_q      <= max_w_d;
        end
    end

    assign free_found = free_found_d;
    assign free_idx   = free_idx_d;
    assign min_idx    = min_idx_d;
    assign max_found  = max_found_d;
    assign max_idx    = max_idx_d;

endmodule

// File: rtl/gam_assoc_layer_controller.sv
// gam_assoc_layer_controller: associative key->response learning and recall; GAM_ASSOC_DECAY_EN enables decay of sibling links on learn
module gam_assoc_layer_controller
    import GAM_package::*;
#(
    parameter int CLASS_W  = ASSOC_CLASS_W,
    parameter int LINKS    = ASSOC_LINKS,
    parameter int WEIGHT_W = ASSOC_WEIGHT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  LEARNING_RECALL_T   learning_recall,
    input  logic               assoc_start,
    input  logic [CLASS_W-1:0] key_class,
    input  logic [CLASS_W-1:0] resp_class,
    output logic               busy,
    output logic               assoc_done,
    output logic               replaced,
    output logic [CLASS_W-1:0] recall_class,
    output logic               recall_found
);

    localparam int SLOT_W = $clog2(LINKS);
    localparam int ROWS   = 2 ** CLASS_W;

    ASSOC_STATE_T       state_q, state_d;
    logic [CLASS_W-1:0] key_q, key_d;
    logic [CLASS_W-1:0] resp_q, resp_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic               hit_q, hit_d;
    logic [SLOT_W-1:0]  hit_idx_q, hit_idx_d;
    logic               replaced_q, replaced_d;
    logic [CLASS_W-1:0] recall_class_q, recall_class_d;
    logic               recall_found_q, recall_found_d;
    assoc_link_t        tbl_q [ROWS][LINKS];
    assoc_link_t        tbl_d [ROWS][LINKS];

    assoc_link_t        cur;
    logic               hit, last, scan_clear, scan_en;
    logic               free_found, max_found;
    logic [SLOT_W-1:0]  free_idx, min_idx, max_idx, tgt;
    logic [WEIGHT_W-1:0] tgt_w;

    assign cur     = tbl_q[key_q][slot_q];
    assign hit     = cur.valid && (cur.resp == resp_q);
    assign last    = slot_q == SLOT_W'(LINKS - 1);
    assign scan_en = (state_q == SCAN_L) || (state_q == SCAN_R);
    assign tgt     = hit_q ? hit_idx_q : (free_found ? free_idx : min_idx);
    assign tgt_w   = tbl_q[key_q][tgt].weight;

    gam_assoc_slot_scan #(
        .LINKS (LINKS),
        .SLOT_W(SLOT_W)
    ) u_scan (
        .clk       (clk),
        .reset     (reset),
        .clear     (scan_clear),
        .en        (scan_en),
        .idx       (slot_q),
        .link      (cur),
        .free_found(free_found),
        .free_idx  (free_idx),
        .min_idx   (min_idx),
        .max_found (max_found),
        .max_idx   (max_idx)
    );

    // Controller next-state, table update and result capture
    always_comb begin
        state_d        = state_q;
        key_d          = key_q;
        resp_d         = resp_q;
        slot_d         = slot_q;
        hit_d          = hit_q;
        hit_idx_d      = hit_idx_q;
        replaced_d     = replaced_q;
        recall_class_d = recall_class_q;
        recall_found_d = recall_found_q;
        tbl_d          = tbl_q;
        scan_clear     = 1'b0;
        case (state_q)
            IDLE: begin
                if (assoc_start) begin
                    key_d      = key_class;
                    resp_d     = resp_class;
                    slot_d     = '0;
                    hit_d      = 1'b0;
                    replaced_d = 1'b0;
                    scan_clear = 1'b1;
                    state_d    = (learning_recall == LEARNING) ? SCAN_L : SCAN_R;
                end
            end
            SCAN_L: begin
                slot_d = slot_q + SLOT_W'(1);
                if (hit) begin
                    hit_d     = 1'b1;
                    hit_idx_d = slot_q;
                    state_d   = UPDATE;
                end else if (last) begin
                    state_d = UPDATE;
                end
            end
            SCAN_R: begin
                slot_d = slot_q + SLOT_W'(1);
                if (last) begin
                    recall_found_d = max_found;
                    recall_class_d = max_found ? tbl_q[key_q][max_idx].resp : '0;
                    state_d        = DONE;
                end
            end
            UPDATE: begin
`ifdef GAM_ASSOC_DECAY_EN
                for (int i = 0; i < LINKS; i++) begin
                    if (tbl_q[key_q][i].valid) begin
                        tbl_d[key_q][i].weight = tbl_q[key_q][i].weight - WEIGHT_W'(1);
                        tbl_d[key_q][i].valid  = tbl_q[key_q][i].weight != WEIGHT_W'(1);
                    end
                end
`endif
                tbl_d[key_q][tgt].valid  = 1'b1;
                tbl_d[key_q][tgt].resp   = resp_q;
                tbl_d[key_q][tgt].weight = !hit_q ? WEIGHT_W'(1) : ((&tgt_w) ? tgt_w : tgt_w + WEIGHT_W'(1));
                replaced_d               = !hit_q && !free_found;
                state_d                  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Controller and table registers; reset clears every link
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            key_q          <= '0;
            resp_q         <= '0;
            slot_q         <= '0;
            hit_q          <= 1'b0;
            hit_idx_q      <= '0;
            replaced_q     <= 1'b0;
            recall_class_q <= '0;
            recall_found_q <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < LINKS; j++) begin
                    tbl_q[i][j] <= '0;
                end
            end
        end else begin
            state_q        <= state_d;
            key_q          <= key_d;
            resp_q         <= resp_d;
            slot_q         <= slot_d;
            hit_q          <= hit_d;
            hit_idx_q      <= hit_idx_d;
            replaced_q     <= replaced_d;
            recall_class_q <= recall_class_d;
            recall_found_q <= recall_found_d;
            tbl_q          <= tbl_d;
        end
    end

    assign busy         = state_q != IDLE;
    assign assoc_done   = state_q == DONE;
    assign replaced     = assoc_done && replaced_q;
    assign recall_class = recall_class_q;
    assign recall_found = recall_found_q;

endmodule

// File: tb/tb_gam_assoc_layer_controller.sv
// tb_gam_assoc_layer_controller: directed learn/recall bench with a slot-table model checked every cycle
module tb_gam_assoc_layer_controller;
    import GAM_package::*;

    localparam int CW   = 4;
    localparam int L    = 4;
    localparam int WW   = 8;
    localparam int ROWS = 16;
    localparam int WMAX = 255;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    LEARNING_RECALL_T learning_recall = LEARNING;
    logic             assoc_start = 1'b0;
    logic [CW-1:0]    key_class = '0;
    logic [CW-1:0]    resp_class = '0;
    logic             busy, assoc_done, replaced, recall_found;
    logic [CW-1:0]    recall_class;

    always #5 clk = ~clk;

    gam_assoc_layer_controller #(.CLASS_W(CW), .LINKS(L), .WEIGHT_W(WW)) dut (
        .clk            (clk),
        .reset          (reset),
        .learning_recall(learning_recall),
        .assoc_start    (assoc_start),
        .key_class      (key_class),
        .resp_class     (resp_class),
        .busy           (busy),
        .assoc_done     (assoc_done),
        .replaced       (replaced),
        .recall_class   (recall_class),
        .recall_found   (recall_found)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit m_v [ROWS][L];
    int m_r [ROWS][L];
    int m_w [ROWS][L];

    int start_cyc = 0, done_cyc = -1, lim = 1 << 30;
    bit exp_rep = 0, pend_recall = 0, pend_rf = 0, exp_rf = 0, chk_en = 0, rep_seen = 0;
    int pend_rc = 0, exp_rc = 0, last_done = -1, done_cnt = 0;
    bit in_op, d_exp;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", n, cyc, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int k = 0; k < ROWS; k++)
            for (int i = 0; i < L; i++) begin
                m_v[k][i] = 0;
                m_r[k][i] = 0;
                m_w[k][i] = 0;
            end
    endfunction

    function automatic void model_learn(input int k, input int r, output int lat, output bit rep);
        int hit = -1, free = -1, mn = -1, tgt;
        for (int i = 0; i < L; i++)
            if (hit < 0 && m_v[k][i] && m_r[k][i] == r) hit = i;
        rep = 0;
        if (hit >= 0) begin
            tgt = hit;
            lat = hit + 3;
            m_w[k][tgt] = (m_w[k][tgt] >= WMAX) ? WMAX : m_w[k][tgt] + 1;
        end else begin
            lat = L + 2;
            for (int i = 0; i < L; i++) begin
                if (free < 0 && !m_v[k][i]) free = i;
                if (m_v[k][i] && (mn < 0 || m_w[k][i] < m_w[k][mn])) mn = i;
            end
            tgt = (free >= 0) ? free : mn;
            rep = free < 0;
            m_v[k][tgt] = 1;
            m_r[k][tgt] = r;
            m_w[k][tgt] = 1;
        end
`ifdef GAM_ASSOC_DECAY_EN
        for (int i = 0; i < L; i++)
            if (i != tgt && m_v[k][i]) begin
                m_w[k][i] = m_w[k][i] - 1;
                if (m_w[k][i] == 0) m_v[k][i] = 0;
            end
`endif
    endfunction

    function automatic void model_recall(input int k, output int lat, output int rc, output bit rf);
        int best = -1;
        for (int i = 0; i < L; i++)
            if (m_v[k][i] && (best < 0 || m_w[k][i] > m_w[k][best])) best = i;
        rf  = best >= 0;
        rc  = rf ? m_r[k][best] : 0;
        lat = L + 1;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            in_op = cyc > start_cyc && cyc <= done_cyc && cyc <= lim;
            d_exp = cyc == done_cyc && cyc <= lim;
            if (d_exp && pend_recall) begin
                exp_rc = pend_rc;
                exp_rf = pend_rf;
            end
            if (assoc_done) begin
                last_done = cyc;
                done_cnt++;
            end
            if (replaced) rep_seen = 1;
            chk("busy", busy, in_op);
            chk("assoc_done", assoc_done, d_exp);
            chk("replaced", replaced, d_exp && exp_rep);
            chk("recall_class", recall_class, exp_rc);
            chk("recall_found", recall_found, exp_rf);
        end
    end

    task automatic op(input LEARNING_RECALL_T m, input int k, input int r, input bit noise);
        int lat, rc;
        bit rep, rf;
        @(posedge clk);
        #1;
        rep = 0;
        rc  = 0;
        rf  = 0;
        if (m == LEARNING) model_learn(k, r, lat, rep);
        else model_recall(k, lat, rc, rf);
        start_cyc   = cyc;
        done_cyc    = cyc + lat;
        lim         = 1 << 30;
        exp_rep     = rep;
        pend_recall = m == RECALL;
        pend_rc     = rc;
        pend_rf     = rf;
        rep_seen    = 0;
        learning_recall = m;
        key_class   = CW'(k);
        resp_class  = CW'(r);
        assoc_start = 1'b1;
        @(posedge clk);
        #1;
        assoc_start = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            if (noise && i == 2) begin
                assoc_start     = 1'b1;
                learning_recall = LEARNING;
                key_class       = 4'hf;
                resp_class      = 4'hf;
            end
            if (noise && i == 3) assoc_start = 1'b0;
            @(posedge clk);
            #1;
        end
        assoc_start = 1'b0;
    endtask

    initial begin
        int d0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_recall_found", recall_found, 0);

        op(LEARNING, 3, 5, 0);
        chk("learn_miss_latency", last_done - start_cyc, 6);
        chk("learn_miss_replaced", rep_seen, 0);
        op(RECALL, 3, 0, 0);
        chk("recall_latency", last_done - start_cyc, 5);
        chk("recall_class_k3", recall_class, 5);
        chk("recall_found_k3", recall_found, 1);

        op(LEARNING, 3, 5, 0);
        chk("learn_hit0_latency_a", last_done - start_cyc, 3);
        op(LEARNING, 3, 5, 0);
        chk("learn_hit0_latency_b", last_done - start_cyc, 3);
        op(LEARNING, 3, 7, 0);
        op(RECALL, 3, 0, 0);
        chk("recall_strongest_k3", recall_class, 5);

        op(LEARNING, 2, 1, 0);
        op(LEARNING, 2, 2, 0);
        op(LEARNING, 2, 3, 0);
        op(LEARNING, 2, 4, 0);
        op(LEARNING, 2, 1, 0);
        op(LEARNING, 2, 9, 0);
`ifndef GAM_ASSOC_DECAY_EN
        chk("evict_replaced_seen", rep_seen, 1);
        chk("model_evict_slot1", m_r[2][1], 9);
`endif
        op(LEARNING, 2, 9, 0);
`ifndef GAM_ASSOC_DECAY_EN
        chk("evicted_slot1_hit_latency", last_done - start_cyc, 4);
`endif

        for (int n = 0; n < 260; n++) op(LEARNING, 1, 6, 0);
        chk("model_saturate", m_w[1][0], 255);
        chk("saturated_hit_latency", last_done - start_cyc, 3);
        op(RECALL, 1, 0, 0);
        chk("recall_saturated_k1", recall_class, 6);

        d0 = done_cnt;
        op(RECALL, 0, 0, 1);
        chk("recall_empty_found", recall_found, 0);
        chk("recall_empty_class", recall_class, 0);
        chk("single_done_with_noise", done_cnt - d0, 1);

`ifdef GAM_ASSOC_DECAY_EN
        op(LEARNING, 4, 1, 0);
        op(LEARNING, 4, 2, 0);
        chk("decay_slot0_invalid", m_v[4][0], 0);
        op(RECALL, 4, 0, 0);
        chk("decay_recall_k4", recall_class, 2);
`endif

        @(posedge clk);
        #1;
        d0          = done_cnt;
        start_cyc   = cyc;
        done_cyc    = cyc + L + 2;
        lim         = 1 << 30;
        exp_rep     = 0;
        pend_recall = 0;
        learning_recall = LEARNING;
        key_class   = 4'd4;
        resp_class  = 4'd3;
        assoc_start = 1'b1;
        @(posedge clk);
        #1;
        assoc_start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        lim   = cyc;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        exp_rc = 0;
        exp_rf = 0;
        model_clear();
        repeat (L + 4) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        op(RECALL, 3, 0, 0);
        chk("table_cleared_k3", recall_found, 0);
        op(RECALL, 4, 0, 0);
        chk("table_cleared_k4", recall_found, 0);

        @(negedge clk);
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
